// File: rtl/fabric_config_loader.sv
// Serialises host configuration words LSB-first into a fabric shift chain,
// then issues a one-cycle commit (cfg_set) and a completion pulse (done).
module fabric_config_loader #(
    parameter  int WORD_W    = 32,
    parameter  int CHAIN_LEN = 40,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_shift,
    output logic              cfg_cen,
    output logic              cfg_set,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [1:0]        state_dbg
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_SET   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] buf_word;
    logic [IDX_W-1:0]  bit_idx;
    logic              buf_valid;
    logic              shift_en;
    logic              last_bit;
    logic              idx_last;

    assign last_bit  = (bit_count == LAST_CNT);
    assign idx_last  = (bit_idx == LAST_IDX);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_SHIFT;
                S_SHIFT: if (shift_en && last_bit) state_nxt = S_SET;
                S_SET:   state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Handshake: a word transfers on a rising edge where word_valid && word_ready;
    // word_ready never depends on word_valid, and data outside a transfer is ignored.
    // Ready opens early on the last buffered bit so consecutive words stream without a gap.
    always_comb begin
        shift_en   = (state == S_SHIFT) && buf_valid && !abort;
        word_ready = (state == S_SHIFT) && !abort &&
                     (!buf_valid || (idx_last && (bit_count < LAST_CNT)));
        cfg_cen    = shift_en;
        cfg_shift  = shift_en && buf_word[bit_idx];
        cfg_set    = (state == S_SET) && !abort;
        done       = (state == S_DONE) && !abort;
        busy       = (state != S_IDLE);
    end

    // Word buffer and bit counter; a finishing shift flushes any unused upper bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_word  <= '0;
            bit_idx   <= '0;
            buf_valid <= 1'b0;
            bit_count <= '0;
        end else if (abort) begin
            buf_valid <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            buf_valid <= 1'b0;
            bit_count <= '0;
        end else begin
            if (shift_en) bit_count <= bit_count + 1'b1;
            if (word_ready && word_valid) begin
                buf_word  <= word_data;
                bit_idx   <= '0;
                buf_valid <= 1'b1;
            end else if (shift_en) begin
                if (idx_last || last_bit) buf_valid <= 1'b0;
                else                      bit_idx   <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: normal load, starvation, abort,
// mid-load reset, start/abort edge cases and a one-bit chain.
module tb_fabric_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, word_valid, word_ready;
    logic [31:0] word_data;
    logic        cfg_shift, cfg_cen, cfg_set, busy, done;
    logic [5:0]  bit_count;
    logic [1:0]  state_dbg;

    logic        b_start, b_word_valid, b_word_ready;
    logic [31:0] b_word_data;
    logic        b_cfg_shift, b_cfg_cen, b_cfg_set, b_busy, b_done;
    logic [0:0]  b_bit_count;
    logic [1:0]  b_state_dbg;

    int n_pass  = 0;
    int n_total = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    fabric_config_loader #(.WORD_W(32), .CHAIN_LEN(40)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .cfg_shift(cfg_shift), .cfg_cen(cfg_cen), .cfg_set(cfg_set),
        .busy(busy), .done(done), .bit_count(bit_count), .state_dbg(state_dbg)
    );

    fabric_config_loader #(.WORD_W(32), .CHAIN_LEN(1)) dut_short (
        .clk(clk), .rst(rst), .start(b_start), .abort(abort),
        .word_data(b_word_data), .word_valid(b_word_valid), .word_ready(b_word_ready),
        .cfg_shift(b_cfg_shift), .cfg_cen(b_cfg_cen), .cfg_set(b_cfg_set),
        .busy(b_busy), .done(b_done), .bit_count(b_bit_count), .state_dbg(b_state_dbg)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commit and chain-enable must never overlap, on either instance.
    always @(negedge clk) begin
        if (rst) begin
            n_total++;
            assert (!(cfg_set && cfg_cen) && !(b_cfg_set && b_cfg_cen)) n_pass++;
            else $error("FAIL set_cen_overlap: observed set=%b/%b cen=%b/%b expected no overlap",
                        cfg_set, b_cfg_set, cfg_cen, b_cfg_cen);
        end
    end

    // Full 40-bit load of w0 then w1; gap > 0 withholds word_valid from cycle 33.
    // A start pulse at cycle 10 lands mid-load and must be ignored.
    task automatic run_load(input logic [31:0] w0, input logic [31:0] w1,
                            input int gap, input string tag);
        logic [31:0] words [2];
        int wi = 0, cen_n = 0, set_n = 0, done_n = 0, bad_bits = 0;
        int first_cen = -1, last_cen = -1, set_cyc = -1, done_cyc = -1, idle_cyc = -1;
        logic ready1 = 1'b0;
        words[0] = w0;
        words[1] = w1;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(w0[i]);
        for (int i = 0; i < 8; i++)  exp_q.push_back(w1[i]);
        start = 1'b1; abort = 1'b0; word_valid = 1'b0;
        #1;
        chk({tag, "_idle_before"}, busy, 1'b0);
        tick();
        for (int cyc = 1; cyc < 120; cyc++) begin
            start      = (cyc == 10);
            word_valid = (wi < 2) && !(cyc >= 33 && cyc < 33 + gap);
            word_data  = (wi < 2) ? words[wi] : 32'hDEAD_BEEF;
            #1;
            if (cyc == 1) ready1 = word_ready;
            if (word_valid && word_ready) wi++;
            if (cfg_cen) begin
                cen_n++;
                if (first_cen < 0) first_cen = cyc;
                last_cen = cyc;
                if (exp_q.size() == 0 || cfg_shift !== exp_q.pop_front()) bad_bits++;
            end
            if (cfg_set) begin set_n++; set_cyc = cyc; end
            if (done) begin done_n++; done_cyc = cyc; end
            if (!busy) begin idle_cyc = cyc; break; end
            tick();
        end
        start = 1'b0; word_valid = 1'b0;
        chk({tag, "_ready_empty"}, ready1, 1'b1);
        chk({tag, "_cen_count"}, cen_n, 40);
        chk({tag, "_bad_bits"}, bad_bits, 0);
        chk({tag, "_first_cen"}, first_cen, 2);
        chk({tag, "_last_cen"}, last_cen, 41 + gap);
        chk({tag, "_cen_low_gap"}, last_cen - first_cen + 1 - cen_n, gap);
        chk({tag, "_set_cycle"}, set_cyc, 42 + gap);
        chk({tag, "_set_pulses"}, set_n, 1);
        chk({tag, "_done_cycle"}, done_cyc, 43 + gap);
        chk({tag, "_done_pulses"}, done_n, 1);
        chk({tag, "_idle_cycle"}, idle_cyc, 44 + gap);
        chk({tag, "_bit_count"}, bit_count, 40);
        chk({tag, "_state_idle"}, state_dbg, 2'd0);
        tick();
        chk({tag, "_bit_count_hold"}, bit_count, 40);
    endtask

    // Watches n cycles and counts any commit/done/enable activity.
    task automatic quiet_window(input int n, input string tag);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (cfg_set || done || cfg_cen || busy) act++;
            tick();
        end
        chk({tag, "_quiet"}, act, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
        b_start = 1'b0; b_word_valid = 1'b0; b_word_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", word_ready, 1'b0);
        chk("rst_bit_count", bit_count, 6'd0);
        chk("rst_cen_set_done", {cfg_cen, cfg_set, done, cfg_shift}, 4'b0000);
        rst = 1'b1;
        tick();

        run_load(32'hA5A5_A5A5, 32'h0000_00F3, 0, "normal");
        run_load(32'hA5A5_A5A5, 32'h0000_00F3, 5, "starve");

        // Abort after 17 bits.
        start = 1'b1; #1; tick(); start = 1'b0;
        word_valid = 1'b1; word_data = 32'hA5A5_A5A5;
        for (int c = 1; c < 19; c++) tick();
        abort = 1'b1;
        #1;
        chk("abort_bit_count", bit_count, 6'd17);
        chk("abort_cen", cfg_cen, 1'b0);
        chk("abort_ready", word_ready, 1'b0);
        tick();
        abort = 1'b0; word_valid = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_state", state_dbg, 2'd0);
        quiet_window(6, "abort");

        // Asynchronous reset after 20 bits.
        start = 1'b1; #1; tick(); start = 1'b0;
        word_valid = 1'b1; word_data = 32'h1234_5678;
        for (int c = 1; c < 22; c++) tick();
        #1;
        chk("prereset_bit_count", bit_count, 6'd20);
        rst = 1'b0;
        #1;
        chk("areset_outputs", {cfg_shift, cfg_cen, cfg_set, word_ready, busy, done}, 6'b0);
        chk("areset_bit_count", bit_count, 6'd0);
        chk("areset_state", state_dbg, 2'd0);
        tick();
        rst = 1'b1; word_valid = 1'b0;
        quiet_window(6, "post_reset");
        run_load(32'hA5A5_A5A5, 32'h0000_00F3, 0, "after_reset");

        // Start together with abort in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        #1;
        chk("start_abort_busy", busy, 1'b0);
        chk("start_abort_state", state_dbg, 2'd0);
        tick();

        // One-bit chain on the short instance.
        b_start = 1'b1; #1; tick(); b_start = 1'b0;
        b_word_valid = 1'b1; b_word_data = 32'hFFFF_FFFE;
        #1;
        chk("short_ready_c1", b_word_ready, 1'b1);
        tick();
        b_word_data = 32'hFFFF_FFFF;
        #1;
        chk("short_cen_c2", b_cfg_cen, 1'b1);
        chk("short_shift_c2", b_cfg_shift, 1'b0);
        chk("short_ready_c2", b_word_ready, 1'b0);
        tick();
        #1;
        chk("short_set_c3", {b_cfg_set, b_cfg_cen, b_word_ready}, 3'b100);
        chk("short_count_c3", b_bit_count, 1'b1);
        tick();
        #1;
        chk("short_done_c4", {b_done, b_cfg_set, b_busy}, 3'b101);
        tick();
        b_word_valid = 1'b0;
        #1;
        chk("short_idle_c5", {b_busy, b_done, b_cfg_cen}, 3'b000);
        chk("short_count_hold", b_bit_count, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fabric_config_loader.md
FABRIC_CONFIG_LOADER -- requirements
Module: fabric_config_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32: width of each host configuration word.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 40: total configuration bits in the target shift chain, legal values 1 or greater.
REQ-003 The block SHALL have derived localparam CNT_W = clog2(CHAIN_LEN+1), the width of the bit counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: begin a configuration load; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of the current load.
REQ-008 The block SHALL have port word_data, input, WORD_W bits: configuration word; bit 0 is shifted first.
REQ-009 The block SHALL have port word_valid, input, 1 bit: word_data is valid.
REQ-010 The block SHALL have port word_ready, output, 1 bit: the loader accepts word_data this cycle.
REQ-011 The block SHALL have port cfg_shift, output, 1 bit: serial bit that drives the chain head (a tile's shift_in_from_north).
REQ-012 The block SHALL have port cfg_cen, output, 1 bit: chain enable, high only on cycles where cfg_shift carries a valid bit.
REQ-013 The block SHALL have port cfg_set, output, 1 bit: one-cycle commit pulse that drives the chain's set_in_from_north.
REQ-014 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-016 The block SHALL have port bit_count, output, CNT_W bits: number of bits shifted in the current load.

Function
REQ-017 The block SHALL implement the state machine IDLE -> SHIFT -> SET -> DONE -> IDLE.
REQ-018 In IDLE, start=1 with abort=0 SHALL cause the next state to be SHIFT, with bit_count cleared to 0 and busy=1.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 The word buffer SHALL hold one word and a bit index 0..WORD_W-1.
REQ-021 In SHIFT, word_ready SHALL be 1 when the buffer is empty, or when the buffer's last needed bit is being shifted this cycle and more bits remain after it.
REQ-022 A word SHALL be accepted only when word_valid=1 and word_ready=1; word_data at any other time SHALL be ignored.
REQ-023 A word accepted in cycle N SHALL present its bit 0 on cfg_shift with cfg_cen=1 in cycle N+1.
REQ-024 Each cycle with cfg_cen=1 SHALL shift exactly one bit, advance the bit index and increment bit_count.
REQ-025 Consecutive words SHALL shift back-to-back with no gap when word_valid is held high.
REQ-026 Starvation (buffer empty, no word accepted) SHALL hold cfg_cen=0 with the chain frozen; no bit is repeated or skipped.
REQ-027 When bit_count reaches CHAIN_LEN, the unused upper bits of the final word SHALL be discarded and word_ready SHALL stay 0 for the rest of the load.
REQ-028 If the last bit is shifted in cycle M, cfg_set SHALL be 1 only in cycle M+1 (state SET) with cfg_cen=0.
REQ-029 done SHALL be 1 only in cycle M+2 (state DONE); busy SHALL deassert in cycle M+3 on the return to IDLE.
REQ-030 abort=1 in any state SHALL return the block to IDLE next cycle, flush the buffer, keep cfg_cen and cfg_set low, and suppress done.
REQ-031 abort and start asserted together in IDLE: abort SHALL win and the block SHALL stay in IDLE.
REQ-032 cfg_set and cfg_cen SHALL never both be 1 in the same cycle.
REQ-033 bit_count SHALL hold its final value (CHAIN_LEN after completion) until the next accepted start.

Reset
REQ-034 rst=0 SHALL immediately force state IDLE, empty the buffer, and drive cfg_shift, cfg_cen, cfg_set, word_ready, busy, done and bit_count to 0.
REQ-035 A reset in the middle of a load SHALL discard that load; no cfg_set or done SHALL follow after reset is released.

Verification
REQ-036 The bench SHALL cover a normal load: WORD_W=32, CHAIN_LEN=40, start, words 0xA5A5_A5A5 then 0x0000_00F3 with valid held -> 40 contiguous cfg_cen cycles, bits LSB-first, word 2 bits 8..31 discarded, cfg_set one cycle later, done the cycle after that, bit_count=40.
REQ-037 The bench SHALL cover starvation: word_valid dropped for 5 cycles after word 1 -> cfg_cen low for exactly those cycles, the serial stream is identical to the normal-load case, and the end-of-load timing follows the last bit.
REQ-038 The bench SHALL cover abort: abort pulsed after 17 bits -> next cycle IDLE, busy=0, with no cfg_set and no done.
REQ-039 The bench SHALL cover an async reset: rst low for 1 cycle after 20 bits -> all outputs 0 immediately; a new start afterwards completes normally.
REQ-040 The bench SHALL cover a chain shorter than one word: CHAIN_LEN=1, one word 0xFFFF_FFFE -> exactly one cfg_cen cycle with cfg_shift=0, then word_ready=0, cfg_set, done.
REQ-041 The bench SHALL cover protocol edge cases: start while busy is ignored; start together with abort leaves the block in IDLE; cfg_set and cfg_cen are never high together (checked by assertion).
